// File: rtl/cmip_irq_svc.sv
// Interrupt service sequencer: snapshots the controller flag vector on irq, dispatches set bits lowest-first, clears and confirms each.
// Latency: trigger seen in IDLE at cycle N -> o_evt_vld at N+3; handshake at M -> o_clr at M+1 -> flag checked from M+2.
// Backpressure: o_evt_vld/o_evt_idx hold until i_evt_rdy; new edge irqs are remembered in a sticky pend bit while busy.
module cmip_irq_svc #(
  parameter int DATA_WDTH = 32,
  parameter int IDX_WDTH  = 5,
  parameter int TMO_WDTH  = 16,
  parameter int CNT_WDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_irq_polar,
  input  logic                 i_irq_level,
  input  logic                 i_irq,
  input  logic [DATA_WDTH-1:0] i_irq_flag,
  output logic [DATA_WDTH-1:0] o_clr,
  output logic                 o_evt_vld,
  output logic [IDX_WDTH-1:0]  o_evt_idx,
  input  logic                 i_evt_rdy,
  input  logic [TMO_WDTH-1:0]  i_tmo_cfg,
  output logic                 o_tmo_err,
  input  logic                 i_tmo_err_clr,
  output logic                 o_busy,
  output logic [CNT_WDTH-1:0]  o_svc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_SEL,
    S_DISP,
    S_CLR,
    S_CHK
  } state_t;

  state_t               state_q;
  logic                 irq_act_d1_q;
  logic                 pend_q;
  logic                 pend_d;
  logic [DATA_WDTH-1:0] snap_q;
  logic [DATA_WDTH-1:0] clr_q;
  logic [IDX_WDTH-1:0]  idx_q;
  logic [TMO_WDTH-1:0]  tmo_q;
  logic                 vld_q;
  logic                 busy_q;
  logic                 tmo_err_q;
  logic [CNT_WDTH-1:0]  cnt_q;

  logic                 irq_act;
  logic                 irq_rise;
  logic                 trigger;
  logic [DATA_WDTH-1:0] idx_oh;
  logic [DATA_WDTH-1:0] snap_rest;
  logic                 flag_gone;
  logic                 tmo_hit;
  logic [IDX_WDTH-1:0]  low_idx;

  assign irq_act   = (i_irq == i_irq_polar);
  assign irq_rise  = irq_act & ~irq_act_d1_q;
  assign trigger   = i_irq_level ? irq_act : pend_q;
  assign idx_oh    = {{(DATA_WDTH-1){1'b0}}, 1'b1} << idx_q;
  assign snap_rest = snap_q & ~idx_oh;
  assign flag_gone = ~|(i_irq_flag & idx_oh);
  assign tmo_hit   = (i_tmo_cfg != '0) && (tmo_q == i_tmo_cfg - TMO_WDTH'(1));

  // Sticky edge-mode pending bit: consumed on IDLE->SNAP, a new rise in the same cycle wins.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE && pend_q) pend_d = 1'b0;
    if (irq_rise) pend_d = 1'b1;
    if (i_irq_level) pend_d = 1'b0;
  end

  // Priority pick of the lowest set bit in the snapshot.
  always_comb begin
    low_idx = '0;
    for (int i = DATA_WDTH - 1; i >= 0; i--) begin
      if (snap_q[i]) low_idx = IDX_WDTH'(i);
    end
  end

  // Service FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      irq_act_d1_q <= 1'b0;
      pend_q       <= 1'b0;
      snap_q       <= '0;
      clr_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      vld_q        <= 1'b0;
      busy_q       <= 1'b0;
      tmo_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      irq_act_d1_q <= irq_act;
      pend_q       <= pend_d;
      clr_q        <= '0;
      if (i_tmo_err_clr) tmo_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q <= S_SNAP;
            busy_q  <= 1'b1;
          end
        end
        S_SNAP: begin
          snap_q <= i_irq_flag;
          if (i_irq_flag == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_SEL;
          end
        end
        S_SEL: begin
          idx_q   <= low_idx;
          vld_q   <= 1'b1;
          state_q <= S_DISP;
        end
        S_DISP: begin
          if (i_evt_rdy) begin
            vld_q   <= 1'b0;
            clr_q   <= idx_oh;
            state_q <= S_CLR;
          end
        end
        S_CLR: begin
          tmo_q   <= '0;
          state_q <= S_CHK;
        end
        S_CHK: begin
          if (flag_gone || tmo_hit) begin
            snap_q <= snap_rest;
            // A confirmed clear is counted; a timed-out one only raises the sticky error.
            if (flag_gone) cnt_q <= cnt_q + CNT_WDTH'(1);
            else           tmo_err_q <= 1'b1;
            if (snap_rest != '0) begin
              state_q <= S_SEL;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            tmo_q <= tmo_q + TMO_WDTH'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clr     = clr_q;
  assign o_evt_vld = vld_q;
  assign o_evt_idx = idx_q;
  assign o_tmo_err = tmo_err_q;
  assign o_busy    = busy_q;
  assign o_svc_cnt = cnt_q;

endmodule

// File: tb/tb_cmip_irq_svc.sv
// Bench for cmip_irq_svc: directed scenarios plus randomized passes against a controller model.
// Expected events per pass are the snapshot's set bits in ascending order, each cleared one-hot.
// The controller model drops a flag bit the cycle after its clear unless the bit is marked stuck.
module tb_cmip_irq_svc;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int TW = 16;
  localparam int CW = 16;

  typedef int iq_t[$];

  logic          clk = 1'b0;
  logic          rst_n, irq_polar, irq_level, irq, evt_rdy, tmo_err_clr;
  logic [DW-1:0] irq_flag;
  logic [TW-1:0] tmo_cfg;
  logic [DW-1:0] clr;
  logic          evt_vld, tmo_err, busy;
  logic [IW-1:0] evt_idx;
  logic [CW-1:0] svc_cnt;

  always #5 clk = ~clk;

  cmip_irq_svc #(.DATA_WDTH(DW), .IDX_WDTH(IW), .TMO_WDTH(TW), .CNT_WDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq_polar(irq_polar), .i_irq_level(irq_level),
    .i_irq(irq), .i_irq_flag(irq_flag), .o_clr(clr), .o_evt_vld(evt_vld),
    .o_evt_idx(evt_idx), .i_evt_rdy(evt_rdy), .i_tmo_cfg(tmo_cfg), .o_tmo_err(tmo_err),
    .i_tmo_err_clr(tmo_err_clr), .o_busy(busy), .o_svc_cnt(svc_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = -10;
  int first_vld = -1;
  int first_err = -1;
  int clr_bad = 0;
  int stab_bad = 0;
  int exp_cnt = 0;
  bit busy_seen = 0;
  bit auto_irq = 0;
  bit rdy_rand = 0;
  bit rdy_force = 1;
  logic [DW-1:0] ctrl_flag = '0;
  logic [DW-1:0] stuck = '0;
  iq_t evt_log;
  logic [DW-1:0] clr_log[$];
  int clr_cyc[$];

  function automatic string q_str(iq_t q);
    string s = "{";
    foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
    return {s, " }"};
  endfunction

  function automatic string clr_str();
    string s = "{";
    foreach (clr_log[i]) s = {s, $sformatf(" %08h", clr_log[i])};
    return {s, " }"};
  endfunction

  function automatic bit q_same(iq_t a, iq_t b);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] != b[i]) return 0;
    return 1;
  endfunction

  function automatic bit clr_seq_ok(iq_t e);
    if (clr_log.size() != e.size()) return 0;
    foreach (e[i]) if (clr_log[i] !== (32'h1 << e[i])) return 0;
    return 1;
  endfunction

  function automatic iq_t bits_of(logic [DW-1:0] f);
    iq_t q;
    for (int i = 0; i < DW; i++) if (f[i]) q.push_back(i);
    return q;
  endfunction

  task automatic clear_logs();
    evt_log.delete();
    clr_log.delete();
    clr_cyc.delete();
    first_vld = -1;
    first_err = -1;
    busy_seen = 0;
  endtask

  // Drive the controller-facing inputs from the model state.
  task automatic apply();
    irq_flag = ctrl_flag;
    if (auto_irq) irq = (ctrl_flag != '0) ? irq_polar : ~irq_polar;
    evt_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  endtask

  // One clock: log handshakes, monitor clear/stability rules, react to clears.
  task automatic tick();
    bit stall, rst_at_edge;
    logic [IW-1:0] sidx;
    logic [DW-1:0] pclr;
    if (evt_vld === 1'b1 && evt_rdy && rst_n) begin
      evt_log.push_back(int'(evt_idx));
      hs_cyc = cyc;
    end
    stall = (evt_vld === 1'b1) && !evt_rdy;
    sidx = evt_idx;
    pclr = clr;
    rst_at_edge = !rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_at_edge && stall && (evt_vld !== 1'b1 || evt_idx !== sidx)) stab_bad++;
    if (clr !== '0) begin
      clr_log.push_back(clr);
      clr_cyc.push_back(cyc);
      if (!$onehot(clr) || pclr !== '0 || cyc != hs_cyc + 1) clr_bad++;
      ctrl_flag = ctrl_flag & ~(clr & ~stuck);
    end
    if (evt_vld === 1'b1 && first_vld < 0) first_vld = cyc;
    if (tmo_err === 1'b1 && first_err < 0) first_err = cyc;
    if (busy === 1'b1) busy_seen = 1;
    apply();
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    int quiet = 0;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (busy !== 1'b0) quiet = 0; else quiet++;
      if (quiet >= 4) begin ok = 1; break; end
    end
  endtask

  task automatic wait_sig(input int which, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if ((which == 0 && evt_vld === 1'b1) || (which == 1 && clr !== '0)) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    checks++; if (clr !== '0) begin failures++; $display("FAIL reset_clr got=%h exp=0", clr); end
    checks++; if (evt_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", evt_vld); end
    checks++; if (evt_idx !== '0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", evt_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (svc_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", svc_cnt); end
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL reset_tmo got=%b exp=0", tmo_err); end
    rst_n = 1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_level();
    iq_t exp;
    bit ok;
    int c0;
    clear_logs();
    irq_level = 1; irq_polar = 1; auto_irq = 1; rdy_rand = 0; rdy_force = 1; stuck = '0;
    ctrl_flag = 32'h0000_0014;
    apply();
    c0 = cyc;
    wait_idle(200, ok);
    exp = {2, 4};
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL level_done got=%b exp=1", ok); end
    checks++; if (first_vld != c0 + 3) begin failures++; $display("FAIL level_latency got=%0d exp=%0d", first_vld - c0, 3); end
    checks++; if (!q_same(evt_log, exp)) begin failures++; $display("FAIL level_events got=%s exp=%s", q_str(evt_log), q_str(exp)); end
    checks++; if (!clr_seq_ok(exp)) begin failures++; $display("FAIL level_clr got=%s exp=00000004,00000010", clr_str()); end
    checks++; if (svc_cnt !== CW'(exp_cnt + 2)) begin failures++; $display("FAIL level_cnt got=%0d exp=%0d", svc_cnt, exp_cnt + 2); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL level_idle got=%b exp=0", busy); end
    exp_cnt += 2;
  endtask

  task automatic test_edge();
    iq_t exp;
    bit ok;
    clear_logs();
    irq_level = 0; irq_polar = 0; auto_irq = 0; irq = 1; rdy_rand = 0; rdy_force = 0;
    ctrl_flag = 32'h8000_0000;
    apply();
    tick();
    tick();
    irq = 0;
    tick();
    irq = 1;
    wait_sig(0, 20, ok);
    checks++; if (ok !== 1'b1 || evt_idx !== 5'd31) begin failures++; $display("FAIL edge_first got_vld=%b idx=%0d exp=1/31", ok, evt_idx); end
    // Second pulse arrives while the first event is still waiting in DISP.
    ctrl_flag = ctrl_flag | 32'h1;
    apply();
    irq = 0;
    tick();
    irq = 1;
    tick();
    tick();
    tick();
    checks++; if (evt_vld !== 1'b1 || evt_idx !== 5'd31) begin failures++; $display("FAIL edge_hold got_vld=%b idx=%0d exp=1/31", evt_vld, evt_idx); end
    rdy_force = 1;
    apply();
    wait_idle(200, ok);
    exp = {31, 0};
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL edge_done got=%b exp=1", ok); end
    checks++; if (!q_same(evt_log, exp)) begin failures++; $display("FAIL edge_events got=%s exp=%s", q_str(evt_log), q_str(exp)); end
    checks++; if (!clr_seq_ok(exp)) begin failures++; $display("FAIL edge_clr got=%s exp=80000000,00000001", clr_str()); end
    checks++; if (svc_cnt !== CW'(exp_cnt + 2)) begin failures++; $display("FAIL edge_cnt got=%0d exp=%0d", svc_cnt, exp_cnt + 2); end
    exp_cnt += 2;
  endtask

  task automatic test_backpressure();
    iq_t exp;
    bit ok;
    clear_logs();
    irq_level = 1; irq_polar = 1; auto_irq = 1; rdy_rand = 0; rdy_force = 0;
    ctrl_flag = 32'h1;
    apply();
    wait_sig(0, 20, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_vld got=%b exp=1", ok); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({evt_vld, evt_idx, clr} !== {1'b1, 5'd0, 32'd0}) begin
        failures++;
        $display("FAIL bp_stall cyc=%0d got vld=%b idx=%0d clr=%h exp 1/0/0", i, evt_vld, evt_idx, clr);
      end
    end
    rdy_force = 1;
    apply();
    tick();
    checks++; if (clr !== 32'h1) begin failures++; $display("FAIL bp_clr got=%h exp=00000001", clr); end
    wait_idle(100, ok);
    exp = {0};
    checks++; if (!q_same(evt_log, exp)) begin failures++; $display("FAIL bp_events got=%s exp=%s", q_str(evt_log), q_str(exp)); end
    checks++; if (svc_cnt !== CW'(exp_cnt + 1)) begin failures++; $display("FAIL bp_cnt got=%0d exp=%0d", svc_cnt, exp_cnt + 1); end
    exp_cnt += 1;
  endtask

  task automatic test_timeout();
    iq_t exp;
    bit ok;
    int gap;
    clear_logs();
    irq_level = 0; irq_polar = 1; auto_irq = 0; irq = 0; rdy_rand = 0; rdy_force = 1;
    tmo_cfg = 16'd8; stuck = 32'h1; ctrl_flag = 32'h9;
    apply();
    tick();
    tick();
    irq = 1;
    tick();
    irq = 0;
    wait_idle(300, ok);
    exp = {0, 3};
    gap = (clr_cyc.size() > 0 && first_err >= 0) ? first_err - clr_cyc[0] : -1;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tmo_done got=%b exp=1", ok); end
    checks++; if (!q_same(evt_log, exp)) begin failures++; $display("FAIL tmo_events got=%s exp=%s", q_str(evt_log), q_str(exp)); end
    checks++; if (!clr_seq_ok(exp)) begin failures++; $display("FAIL tmo_clr got=%s exp=00000001,00000008", clr_str()); end
    checks++; if (tmo_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", tmo_err); end
    checks++; if (gap != 9) begin failures++; $display("FAIL tmo_time got=%0d exp=9", gap); end
    checks++; if (svc_cnt !== CW'(exp_cnt + 1)) begin failures++; $display("FAIL tmo_cnt got=%0d exp=%0d", svc_cnt, exp_cnt + 1); end
    exp_cnt += 1;
    tmo_err_clr = 1;
    tick();
    tmo_err_clr = 0;
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL tmo_err_clr got=%b exp=0", tmo_err); end
    stuck = '0; ctrl_flag = '0; tmo_cfg = '0;
    apply();
    tick();
  endtask

  task automatic test_spurious();
    bit ok;
    clear_logs();
    irq_level = 1; irq_polar = 1; auto_irq = 0; rdy_rand = 0; rdy_force = 1; ctrl_flag = '0;
    apply();
    irq = 1;
    for (int i = 0; i < 6; i++) tick();
    irq = 0;
    wait_idle(50, ok);
    checks++; if (ok !== 1'b1 || busy_seen !== 1'b1) begin failures++; $display("FAIL spur_run got done=%b busy_seen=%b exp=1/1", ok, busy_seen); end
    checks++; if (first_vld != -1 || evt_log.size() != 0) begin failures++; $display("FAIL spur_vld got first_vld=%0d exp=-1", first_vld); end
    checks++; if (clr_log.size() != 0) begin failures++; $display("FAIL spur_clr got=%s exp={ }", clr_str()); end
    checks++; if (svc_cnt !== CW'(exp_cnt)) begin failures++; $display("FAIL spur_cnt got=%0d exp=%0d", svc_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    iq_t exp;
    bit ok;
    clear_logs();
    irq_level = 1; irq_polar = 1; auto_irq = 1; rdy_rand = 0; rdy_force = 1;
    ctrl_flag = 32'h4;
    apply();
    wait_sig(1, 20, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_clr_seen got=%b exp=1", ok); end
    rst_n = 0;
    tick();
    checks++;
    if ({clr, evt_vld, busy, tmo_err} !== '0 || svc_cnt !== '0) begin
      failures++;
      $display("FAIL rstmid_state got clr=%h vld=%b busy=%b err=%b cnt=%0d exp all 0", clr, evt_vld, busy, tmo_err, svc_cnt);
    end
    exp_cnt = 0;
    ctrl_flag = 32'h2;
    apply();
    tick();
    rst_n = 1;
    clear_logs();
    wait_idle(100, ok);
    exp = {1};
    checks++; if (!q_same(evt_log, exp)) begin failures++; $display("FAIL rstmid_events got=%s exp=%s", q_str(evt_log), q_str(exp)); end
    checks++; if (!clr_seq_ok(exp) || svc_cnt !== CW'(1)) begin failures++; $display("FAIL rstmid_after got clr=%s cnt=%0d exp=00000002/1", clr_str(), svc_cnt); end
    exp_cnt = 1;
  endtask

  task automatic test_random();
    iq_t exp;
    bit ok, lvl, p;
    logic [DW-1:0] f;
    for (int it = 0; it < 20; it++) begin
      lvl = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       f = '0;
        1:       f = 32'h1 << $urandom_range(0, 31);
        default: f = $urandom & $urandom;
      endcase
      clear_logs();
      ctrl_flag = '0; auto_irq = 0; stuck = '0; rdy_rand = 1;
      tmo_cfg = TW'($urandom_range(0, 3));
      irq_level = lvl; irq_polar = p; irq = ~p;
      apply();
      tick();
      tick();
      ctrl_flag = f;
      if (lvl) begin
        auto_irq = 1;
        apply();
      end else begin
        apply();
        irq = p;
        tick();
        irq = ~p;
      end
      wait_idle(3000, ok);
      exp = bits_of(f);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rnd_done it=%0d flag=%h got=%b exp=1", it, f, ok); end
      checks++; if (!q_same(evt_log, exp)) begin failures++; $display("FAIL rnd_events it=%0d flag=%h got=%s exp=%s", it, f, q_str(evt_log), q_str(exp)); end
      checks++; if (!clr_seq_ok(exp)) begin failures++; $display("FAIL rnd_clr it=%0d flag=%h got=%0d clears", it, f, clr_log.size()); end
      checks++; if (svc_cnt !== CW'(exp_cnt + $countones(f))) begin failures++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, svc_cnt, exp_cnt + $countones(f)); end
      exp_cnt += $countones(f);
    end
    rdy_rand = 0;
    checks++; if (stab_bad != 0) begin failures++; $display("FAIL vld_stable got=%0d violations exp=0", stab_bad); end
    checks++; if (clr_bad != 0) begin failures++; $display("FAIL clr_pulse got=%0d violations exp=0", clr_bad); end
  endtask

  initial begin
    rst_n = 0; irq_polar = 1; irq_level = 1; irq = 0; evt_rdy = 1;
    tmo_err_clr = 0; irq_flag = '0; tmo_cfg = '0;
    test_reset();
    test_level();
    test_edge();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
